conv1_relu_pool: RTL and testbench
==================================

// Module: conv1_relu_pool
// PURPOSE
//  Post-processing stage directly downstream of the 6-channel 5x5 conv PE group.
//  - Takes the six raw 32-bit accumulator results per output pixel.
//  - Applies ReLU, then rounding right-shift requantisation with saturation.
//  - Applies 2x2/stride-2 max-pooling over the IN_W x IN_H conv map.
//  - Emits 9-bit pixels, raster order, ready for the next conv layer's window builder.
// PARAMETERS
//  IN_WIDTH   32  signed accumulator width from the PE group
//  OUT_WIDTH  9   signed output pixel width; outputs are always >= 0
//  SHIFT      8   requant right shift; must be >= 1
//  IN_W       24  conv map width; must be even
//  IN_H       24  conv map height; must be even
// PORTS
//  clk                clock
//  rst                in   1          async, active-high reset
//  frame_rst          in   1          sync restart: counters -> 0, sat_flag cleared
//  valid_in           in   1          result_ch0..5 valid (PE group result_valid)
//  result_ch0..ch5    in   IN_WIDTH   signed conv results, raster order
//  valid_out          in/out: out 1   pooled pixel valid, 1-cycle pulse
//  pool_ch0..ch5      out  OUT_WIDTH  pooled pixels, range 0..SAT_MAX
//  out_last           out  1          high with the last pooled pixel of the frame
//  sat_flag           out  1          sticky: some channel saturated this frame
// BEHAVIOUR
//  - Reset: all outputs 0, row/col counters 0, horizontal register 0.
//    Row buffer is not reset; it is always written before it is read.
//  - No backpressure. valid_in may have arbitrary bubbles; state holds while valid_in=0.
//  - Stage 1 (registered, per channel), with SAT_MAX = 2^(OUT_WIDTH-1)-1:
//      q = (x <= 0) ? 0 : min((x + 2^(SHIFT-1)) >>> SHIFT, SAT_MAX)
//    The add is done in IN_WIDTH+1 bits, so there is no wrap.
//    sat_flag is set on any clamp.
//  - Stage 2 counters: col 0..IN_W-1 and row 0..IN_H-1, advanced per stage-1 valid.
//    col wraps -> row++. At row=IN_H-1, col=IN_W-1 both wrap to 0 (next frame back-to-back).
//  - Horizontal pair:
//      even col: hreg <= q.
//      odd col:  h = max(hreg, q).
//  - Vertical pair:
//      even row, odd col: rowbuf[col>>1] <= h (IN_W/2 entries x 6 channels).
//      odd row, odd col:  pool_chN <= max(rowbuf[col>>1], h); valid_out = 1.
//  - Latency: valid_out is 2 cycles after the valid_in of each (odd row, odd col) input.
//    pool_chN holds its value between pulses.
//  - out_last = valid_out for the pixel from row IN_H-1, col IN_W-1.
//    Output count is (IN_W/2)*(IN_H/2) per frame.
//  - frame_rst:
//    - Zeroes counters and hreg, and clears sat_flag.
//    - Any in-flight stage-1 data is discarded; valid_out is never generated from it.
//    - If valid_in is high in the same cycle, that pixel is taken as row 0, col 0 of the new frame.
//    - sat_flag is then set normally if that pixel saturates.
//  - rst mid-frame: the partial frame is discarded and the next valid_in is row 0, col 0.
//  - Max comparison is unsigned on q (q >= 0). Ties give the same value, no ambiguity.
// TESTING
//  1. Assert rst -> all outputs 0. Release, no valid_in for 50 cycles -> valid_out stays 0.
//  2. Ramp frame: ch0 x = (r+c)<<8, contiguous valid_in.
//     -> 144 pulses; pool(i,j) = 2(i+j)+2, so (0,0)=2 and (11,11)=46.
//     -> out_last only on the 144th pulse; each pulse 2 cycles after its odd/odd input.
//  3. ch1 = -1000 everywhere -> all 0.
//     ch2 = 300<<8 -> all 255 and sat_flag = 1.
//     ch3 = 0 -> 0 and no sat_flag.
//  4. Rounding: 2x2 block all 383 -> 1. Block all 384 -> 2.
//     Block {0, -5, 640, 100} -> 3 (640 -> 3, 100 -> 0).
//  5. Ramp frame of test 2 with valid_in high 1 cycle in 3 -> identical 144 values and order.
//  6. Abort mid-frame:
//     - frame_rst at input pixel 100, coincident with valid_in, then a full ramp frame
//       -> exactly 144 outputs matching test 2.
//     - Repeat with async rst at pixel 300 -> same result.

Source files
------------

// File: rtl/conv1_relu_pool.sv
// Conv1 post-processing: per-channel ReLU + rounding requant with saturation,
// then 2x2/stride-2 max-pool over the conv map, six channels in lock-step.

module conv1_relu_pool_lane #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 9,
    parameter int SHIFT     = 8,
    parameter int IN_W      = 24,
    parameter int IW        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_rst,
    input  logic                       valid_in,
    input  logic signed [IN_WIDTH-1:0] x,
    input  logic                       st2,
    input  logic                       col_odd,
    input  logic                       row_odd,
    input  logic [IW-1:0]              idx,
    output logic                       sat,
    output logic [OUT_WIDTH-1:0]       pool
);
    localparam int SAT_MAX = 2**(OUT_WIDTH-1) - 1;
    localparam logic [IN_WIDTH:0]    SAT_EXT = (IN_WIDTH+1)'(SAT_MAX);
    localparam logic [OUT_WIDTH-1:0] SAT_Q   = OUT_WIDTH'(SAT_MAX);
    localparam logic [IN_WIDTH:0]    RND     = (IN_WIDTH+1)'(1) << (SHIFT-1);

    logic [IN_WIDTH:0]    sum, shr;
    logic                 pos, clamp;
    logic [OUT_WIDTH-1:0] q_next, q, hreg, h, rb;
    logic [OUT_WIDTH-1:0] rowbuf [IN_W/2];

    // One extra bit on the add so the rounding offset can never wrap.
    assign sum    = {x[IN_WIDTH-1], x} + RND;
    assign shr    = sum >> SHIFT;
    assign pos    = !x[IN_WIDTH-1] && (|x);
    assign clamp  = pos && (shr > SAT_EXT);
    assign q_next = !pos ? '0 : (clamp ? SAT_Q : shr[OUT_WIDTH-1:0]);
    assign sat    = valid_in && clamp;

    assign h  = (q > hreg) ? q : hreg;
    assign rb = rowbuf[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            hreg <= '0;
            pool <= '0;
        end else begin
            if (valid_in) q <= q_next;
            if (frame_rst) hreg <= '0;
            else if (st2 && !col_odd) hreg <= q;
            if (st2 && col_odd && row_odd) pool <= (rb > h) ? rb : h;
        end
    end

    // Row buffer needs no reset: an even row always fills it before the odd row reads.
    always_ff @(posedge clk) begin
        if (st2 && col_odd && !row_odd) rowbuf[idx] <= h;
    end
endmodule

module conv1_relu_pool #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 9,
    parameter int SHIFT     = 8,
    parameter int IN_W      = 24,
    parameter int IN_H      = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_rst,
    input  logic                       valid_in,
    input  logic signed [IN_WIDTH-1:0] result_ch0,
    input  logic signed [IN_WIDTH-1:0] result_ch1,
    input  logic signed [IN_WIDTH-1:0] result_ch2,
    input  logic signed [IN_WIDTH-1:0] result_ch3,
    input  logic signed [IN_WIDTH-1:0] result_ch4,
    input  logic signed [IN_WIDTH-1:0] result_ch5,
    output logic                       valid_out,
    output logic [OUT_WIDTH-1:0]       pool_ch0,
    output logic [OUT_WIDTH-1:0]       pool_ch1,
    output logic [OUT_WIDTH-1:0]       pool_ch2,
    output logic [OUT_WIDTH-1:0]       pool_ch3,
    output logic [OUT_WIDTH-1:0]       pool_ch4,
    output logic [OUT_WIDTH-1:0]       pool_ch5,
    output logic                       out_last,
    output logic                       sat_flag
);
    localparam int NUM_LANES = 6;
    localparam int CW = $clog2(IN_W);
    localparam int RW = $clog2(IN_H);

    logic [NUM_LANES-1:0][IN_WIDTH-1:0]  res;
    logic [NUM_LANES-1:0][OUT_WIDTH-1:0] pool;
    logic [NUM_LANES-1:0]                sat_lane;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          s1_valid, st2, col_end, row_end;

    assign res = {result_ch5, result_ch4, result_ch3, result_ch2, result_ch1, result_ch0};
    // frame_rst kills whatever sits in stage 1 this cycle.
    assign st2     = s1_valid && !frame_rst;
    assign col_end = (col == CW'(IN_W-1));
    assign row_end = (row == RW'(IN_H-1));

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        conv1_relu_pool_lane #(
            .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT),
            .IN_W(IN_W), .IW(CW-1)
        ) u_lane (
            .clk(clk), .rst(rst), .frame_rst(frame_rst), .valid_in(valid_in),
            .x(res[i]), .st2(st2), .col_odd(col[0]), .row_odd(row[0]),
            .idx(col[CW-1:1]), .sat(sat_lane[i]), .pool(pool[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            col       <= '0;
            row       <= '0;
            valid_out <= 1'b0;
            out_last  <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            s1_valid  <= valid_in;
            valid_out <= st2 && col[0] && row[0];
            out_last  <= st2 && col_end && row_end;
            if (frame_rst) sat_flag <= |sat_lane;
            else if (|sat_lane) sat_flag <= 1'b1;
            if (frame_rst) begin
                col <= '0;
                row <= '0;
            end else if (st2) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign pool_ch0 = pool[0];
    assign pool_ch1 = pool[1];
    assign pool_ch2 = pool[2];
    assign pool_ch3 = pool[3];
    assign pool_ch4 = pool[4];
    assign pool_ch5 = pool[5];
endmodule

// File: tb/tb_conv1_relu_pool.sv
// Scoreboard bench for conv1_relu_pool: frames are generated per channel, the
// pooled result is computed arithmetically from the whole frame and queued.
module tb_conv1_relu_pool;
    localparam int W = 24;
    localparam int H = 24;

    typedef struct {
        logic [5:0][8:0] v;
        bit              last;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst, frame_rst, valid_in;
    logic signed [31:0] res [6];
    logic valid_out, out_last, sat_flag;
    logic [8:0] pool [6];

    int   cyc = 0;
    int   total = 0, bad = 0;
    int   n_out = 0, n_last = 0;
    int   fr [6][H][W];
    exp_t sbq [$];
    bit   sat_exp;

    conv1_relu_pool dut (
        .clk(clk), .rst(rst), .frame_rst(frame_rst), .valid_in(valid_in),
        .result_ch0(res[0]), .result_ch1(res[1]), .result_ch2(res[2]),
        .result_ch3(res[3]), .result_ch4(res[4]), .result_ch5(res[5]),
        .valid_out(valid_out),
        .pool_ch0(pool[0]), .pool_ch1(pool[1]), .pool_ch2(pool[2]),
        .pool_ch3(pool[3]), .pool_ch4(pool[4]), .pool_ch5(pool[5]),
        .out_last(out_last), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ReLU, round-half-up divide by 256, clamp to 255.
    function automatic int qref(int x, output bit s);
        longint v;
        s = 0;
        if (x <= 0) return 0;
        v = (longint'(x) + 128) / 256;
        if (v > 255) begin
            s = 1;
            return 255;
        end
        return int'(v);
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drop an expected pulse that a reset issued now would kill in flight.
    task automatic discard();
        if (sbq.size() > 0 && sbq[$].cyc == cyc + 1) void'(sbq.pop_back());
    endtask

    task automatic drive(bit frst, int r, int c);
        exp_t e;
        bit   s;
        int   m, t;
        @(posedge clk); #1;
        if (frst) begin
            discard();
            sat_exp = 0;
        end
        frame_rst = frst;
        valid_in  = 1'b1;
        for (int ch = 0; ch < 6; ch++) begin
            res[ch] = fr[ch][r][c];
            void'(qref(fr[ch][r][c], s));
            if (s) sat_exp = 1;
        end
        if ((r % 2) == 1 && (c % 2) == 1) begin
            for (int ch = 0; ch < 6; ch++) begin
                m = 0;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++) begin
                        t = qref(fr[ch][r-dr][c-dc], s);
                        if (t > m) m = t;
                    end
                e.v[ch] = 9'(m);
            end
            e.last = (r == H-1) && (c == W-1);
            e.cyc  = cyc + 2;
            sbq.push_back(e);
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_in  = 1'b0;
            frame_rst = 1'b0;
            for (int ch = 0; ch < 6; ch++) res[ch] = $urandom;
        end
    endtask

    task automatic run_frame(int gap, bit frst, int stop_after, bit rnd_gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (r*W + c >= stop_after) return;
                drive(frst && r == 0 && c == 0, r, c);
                idle(rnd_gap ? int'($urandom_range(0, 3)) : gap);
            end
    endtask

    function automatic int rnd_val();
        int pick[11] = '{0, -1, 1, 127, 128, 383, 384, 65407, 65408, 32'h7fffffff, 32'h80000000};
        case ($urandom_range(0, 4))
            0: return int'($urandom);
            1: return int'($urandom_range(0, 6000)) - 3000;
            2: return 65408 + int'($urandom_range(0, 600)) - 300;
            3: return int'($urandom_range(0, 70000));
            default: return pick[$urandom_range(0, 10)];
        endcase
    endfunction

    // 0: directed channel mix, 1: random, 2: non-saturating mix
    task automatic fill(int mode);
        int blk [4] = '{0, -5, 640, 100};
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int ch = 0; ch < 6; ch++) begin
                    if (mode == 1) fr[ch][r][c] = rnd_val();
                    else if (mode == 2) fr[ch][r][c] = (ch == 3) ? 65407 : ((r*c) << 6) + ch*17;
                    else case (ch)
                        0: fr[ch][r][c] = (r + c) << 8;
                        1: fr[ch][r][c] = -1000;
                        2: fr[ch][r][c] = 300 << 8;
                        3: fr[ch][r][c] = 0;
                        4: case (((r/2) + (c/2)) % 3)
                               0: fr[ch][r][c] = 383;
                               1: fr[ch][r][c] = 384;
                               default: fr[ch][r][c] = blk[(r%2)*2 + (c%2)];
                           endcase
                        default: fr[ch][r][c] = int'($urandom_range(0, 70000)) - 1000;
                    endcase
                end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [5:0][8:0] act;
        if (!rst && valid_out) begin
            n_out++;
            if (out_last) n_last++;
            act = {pool[5], pool[4], pool[3], pool[2], pool[1], pool[0]};
            if (sbq.size() == 0) begin
                check("unexpected valid_out", 1, 0);
            end else begin
                e = sbq.pop_front();
                total++;
                if (act !== e.v) begin
                    bad++;
                    $display("FAIL pool data: got %h expected %h", act, e.v);
                end
                check("out_last", int'(out_last), int'(e.last));
                check("pulse cycle", cyc, e.cyc);
            end
        end
    end

    task automatic frame_counts(string name, int n0, int l0);
        idle(4);
        check({name, " pulses"}, n_out - n0, 144);
        check({name, " last"}, n_last - l0, 1);
        check({name, " sat_flag"}, int'(sat_flag), int'(sat_exp));
    endtask

    initial begin
        int n0, l0;
        rst = 1'b1; frame_rst = 1'b0; valid_in = 1'b0;
        for (int ch = 0; ch < 6; ch++) res[ch] = '0;
        sat_exp = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset valid_out", int'(valid_out), 0);
        check("reset out_last", int'(out_last), 0);
        check("reset sat_flag", int'(sat_flag), 0);
        for (int ch = 0; ch < 6; ch++) check("reset pool", int'(pool[ch]), 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(50);
        check("idle pulses", n_out, 0);

        // directed ramp / constant / rounding frame, contiguous
        fill(0); n0 = n_out; l0 = n_last;
        run_frame(0, 0, W*H, 0);
        frame_counts("directed", n0, l0);

        // non-saturating frame after frame_rst clears the sticky flag
        fill(2); n0 = n_out; l0 = n_last;
        run_frame(0, 1, W*H, 0);
        frame_counts("nosat", n0, l0);

        // one valid in three
        fill(0); n0 = n_out; l0 = n_last;
        run_frame(2, 1, W*H, 0);
        frame_counts("bubbles", n0, l0);

        // frame_rst at pixel 100 carrying the new frame's first pixel
        fill(0);
        run_frame(0, 1, 100, 0);
        n0 = n_out; l0 = n_last;
        run_frame(0, 1, W*H, 0);
        frame_counts("frame_rst abort", n0, l0);

        // frame_rst right behind an odd/odd pixel: its pulse must vanish
        fill(1);
        run_frame(0, 1, W + 2, 0);
        n0 = n_out; l0 = n_last;
        fill(1);
        run_frame(0, 1, W*H, 0);
        frame_counts("in-flight discard", n0, l0);

        // async reset at pixel 300
        fill(0);
        run_frame(0, 1, 300, 0);
        @(posedge clk); #1;
        discard();
        rst = 1'b1; valid_in = 1'b0; frame_rst = 1'b0; sat_exp = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n0 = n_out; l0 = n_last;
        run_frame(0, 0, W*H, 0);
        frame_counts("rst abort", n0, l0);

        // random frames, the second back-to-back with no frame_rst
        fill(1); n0 = n_out; l0 = n_last;
        run_frame(0, 1, W*H, 1);
        fill(1);
        run_frame(0, 0, W*H, 0);
        idle(4);
        check("random pulses", n_out - n0, 288);
        check("random last", n_last - l0, 2);
        check("random sat_flag", int'(sat_flag), int'(sat_exp));

        for (int i = 0; i < 10 && sbq.size() > 0; i++) idle(1);
        check("scoreboard drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
